// File: rtl/tt16_uart_pkg.sv
// Shared types and line levels for the FIFO-drain UART transmitter.
package tt16_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: bit_end_o marks the last clk of each serial bit.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  output logic bit_end_o,
  output logic bit_end_nxt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)            cnt_d = CNT_W'(CLKS_PER_BIT - 1);
    else if (cnt_q != '0)  cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bit_end_o     = (cnt_q == '0);
  // Lets the owner register outputs that must line up with the last bit cycle.
  assign bit_end_nxt_o = (cnt_d == '0);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops FIFO nibbles and sends each as start/data(LSB first)/stop on tx.
// Define FIFO_UART_TX_PARITY_EN to add an even-parity bit after the data bits.
module fifo_uart_tx
  import tt16_uart_pkg::*;
#(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_en,
  input  logic              empty,
  input  logic [DATA_W-1:0] rdata,
  output logic              rinc,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int BC_W  = $clog2(DATA_W + 1);

  uart_state_e       state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic              tx_q, tx_d, busy_q, busy_d, fd_q, fd_d;
  logic              pop, load, bit_end, bit_end_nxt;

  assign pop  = (state_q == IDLE) & tx_en & ~empty & ~rst;
  assign load = pop | (bit_end & (state_q != IDLE));
  assign rinc = pop;

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_timer (
    .clk           (clk),
    .rst           (rst),
    .load_i        (load),
    .bit_end_o     (bit_end),
    .bit_end_nxt_o (bit_end_nxt)
  );

`ifdef FIFO_UART_TX_PARITY_EN
  logic par_q, par_d;
  assign par_d = pop ? ^rdata : par_q;
  always_ff @(posedge clk) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      IDLE: if (pop) begin
        state_d   = START;
        shreg_d   = rdata;
        bit_cnt_d = '0;
      end
      START: if (bit_end) state_d = DATA;
      DATA: if (bit_end) begin
        shreg_d = shreg_q >> 1;
        if (bit_cnt_q == BC_W'(DATA_W - 1)) begin
`ifdef FIFO_UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end else begin
          bit_cnt_d = bit_cnt_q + BC_W'(1);
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: if (bit_end) state_d = STOP;
`endif
      STOP: if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode the next state so the registered pins align with state_q.
  always_comb begin
    tx_d = IDLE_LEVEL;
    case (state_d)
      START:  tx_d = START_BIT;
      DATA:   tx_d = shreg_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: tx_d = par_d;
`endif
      STOP:   tx_d = STOP_BIT;
      default: tx_d = IDLE_LEVEL;
    endcase
    busy_d = (state_d != IDLE);
    fd_d   = (state_d == STOP) & bit_end_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= IDLE_LEVEL;
      busy_q    <= 1'b0;
      fd_q      <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      fd_q      <= fd_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a small FIFO model; second instance at CLKS_PER_BIT=1.
module tb_fifo_uart_tx;

  localparam int DW  = 4;
  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NB = DW + 3;
`else
  localparam int NB = DW + 2;
`endif
  localparam int FL = NB * CPB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, tx_en, empty, rinc, tx, busy, frame_done;
  logic [3:0] rdata;
  logic [3:0] mem [8];
  int         wp = 0;
  int         rp = 0;

  assign empty = (wp == rp);
  assign rdata = mem[rp % 8];
  always @(posedge clk) if (rinc) rp <= rp + 1;

  logic       tx_en1, rinc1, tx1, busy1, fd1;
  logic       empty1 = 1'b0;
  logic [3:0] rdata1 = 4'hA;

  int checks   = 0;
  int failures = 0;

  fifo_uart_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) u_dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .empty(empty), .rdata(rdata),
    .rinc(rinc), .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  fifo_uart_tx #(.DATA_W(DW), .CLKS_PER_BIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .tx_en(tx_en1), .empty(empty1), .rdata(rdata1),
    .rinc(rinc1), .tx(tx1), .busy(busy1), .frame_done(fd1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_tx(input logic [3:0] w, input int i, input int cpb);
    int b;
    b = i / cpb;
    if (b == 0)      return 1'b0;
    if (b <= DW)     return w[b-1];
    if (b == NB - 1) return 1'b1;
    return ^w;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] w);
    mem[wp % 8] = w;
    wp++;
  endtask

  // Called in the rinc cycle; ends in the last stop-bit cycle.
  task automatic frame(input logic [3:0] w, input int hook);
    for (int i = 0; i < FL; i++) begin
      cyc();
      chk("frame_tx", tx, exp_tx(w, i, CPB));
      chk("frame_busy", busy, 1);
      chk("frame_done", frame_done, (i == FL - 1));
      chk("frame_rinc", rinc, 0);
      if (i == hook) begin
        tx_en = 1'b0;
        push(4'h6);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tx_en = 1'b1; tx_en1 = 1'b0;
    push(4'hA);
    repeat (3) begin
      cyc();
      chk("rst_rinc", rinc, 0);
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_fdone", frame_done, 0);
    end
    rst = 1'b0; #1;
    chk("first_rinc", rinc, 1);
    frame(4'hA, -1);
    cyc();
    chk("idle_tx", tx, 1);
    chk("idle_busy", busy, 0);
    chk("idle_empty_rinc", rinc, 0);

    // back-to-back frames
    tx_en = 1'b0;
    push(4'h3);
    push(4'hC);
    cyc();
    chk("en_off_rinc", rinc, 0);
    tx_en = 1'b1; #1;
    chk("b2b_rinc0", rinc, 1);
    frame(4'h3, -1);
    cyc();
    chk("gap_tx", tx, 1);
    chk("gap_busy", busy, 0);
    chk("gap_rinc", rinc, 1);
    frame(4'hC, -1);
    repeat (3) begin
      cyc();
      chk("empty_rinc", rinc, 0);
      chk("empty_tx", tx, 1);
    end

    // tx_en dropped mid-frame: frame finishes, no further pop
    push(4'h5); #1;
    chk("en_rinc", rinc, 1);
    frame(4'h5, 6);
    repeat (4) begin
      cyc();
      chk("en_low_rinc", rinc, 0);
      chk("en_low_busy", busy, 0);
    end
    tx_en = 1'b1; #1;
    chk("en_back_rinc", rinc, 1);
    frame(4'h6, -1);

    // reset in the middle of a frame
    cyc();
    push(4'h9); #1;
    chk("rstmid_rinc", rinc, 1);
    repeat (10) cyc();
    chk("pre_rst_tx", tx, 0);
    push(4'h2);
    rst = 1'b1;
    cyc();
    chk("rstmid_tx", tx, 1);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_fdone", frame_done, 0);
    chk("rstmid_rinc", rinc, 0);
    rst = 1'b0; #1;
    chk("post_rst_rinc", rinc, 1);
    frame(4'h2, -1);
    cyc();
    chk("post_rst_idle_busy", busy, 0);

    // one clk per bit
    tx_en1 = 1'b1; #1;
    chk("cpb1_rinc", rinc1, 1);
    for (int i = 0; i < NB; i++) begin
      cyc();
      if (i == 0) tx_en1 = 1'b0;
      chk("cpb1_tx", tx1, exp_tx(4'hA, i, 1));
      chk("cpb1_busy", busy1, 1);
      chk("cpb1_fdone", fd1, (i == NB - 1));
    end
    cyc();
    chk("cpb1_idle_tx", tx1, 1);
    chk("cpb1_idle_busy", busy1, 0);
    chk("cpb1_idle_rinc", rinc1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
